// File: rtl/mem_port_ctrl_if.sv
// Request/response and memory-bus signals of the memory-port sequencer.
// The bidirectional data bus is carried as a separate port on the controller.
interface mem_port_ctrl_if #(
    parameter int unsigned WORD_SIZE = 16
);
    logic                 req_valid;
    logic                 req_write;
    logic                 req_is_inst;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 req_ready;
    logic                 done;
    logic [WORD_SIZE-1:0] ir_out;
    logic [WORD_SIZE-1:0] mdr_out;
    logic [WORD_SIZE-1:0] inst_count;
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;

    // Controller side
    modport slave (
        input  req_valid, req_write, req_is_inst, req_addr, req_wdata,
        output req_ready, done, ir_out, mdr_out, inst_count, readM, writeM, address
    );

    // CPU control FSM / memory side
    modport master (
        output req_valid, req_write, req_is_inst, req_addr, req_wdata,
        input  req_ready, done, ir_out, mdr_out, inst_count, readM, writeM, address
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// Memory-port sequencer: turns each control-FSM request into a fixed-latency
// word-memory access, captures fetch data into IR and load data into MDR, and
// counts completed instruction fetches.
module mem_port_ctrl #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned MEM_LATENCY = 2    // legal range 1..15
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    mem_port_ctrl_if.slave       bus,
    inout  wire  [WORD_SIZE-1:0] data
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    // Strobe already covers the acceptance cycle, so count down from latency-1.
    localparam logic [3:0] WaitInit = 4'(MEM_LATENCY - 1);

    state_e               state_q;
    logic [3:0]           wait_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 is_inst_q;
    logic                 done_q;
    logic                 readm_q;
    logic                 writem_q;
    logic [WORD_SIZE-1:0] ir_q;
    logic [WORD_SIZE-1:0] mdr_q;
    logic [WORD_SIZE-1:0] inst_count_q;

    // Access sequencer: accept in idle, hold the strobe, capture on the last edge.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            is_inst_q    <= 1'b0;
            done_q       <= 1'b0;
            readm_q      <= 1'b0;
            writem_q     <= 1'b0;
            ir_q         <= '0;
            mdr_q        <= '0;
            inst_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        addr_q    <= bus.req_addr;
                        wdata_q   <= bus.req_wdata;
                        is_inst_q <= bus.req_is_inst;
                        wait_q    <= WaitInit;
                        if (bus.req_write) begin
                            state_q  <= StWrite;
                            writem_q <= 1'b1;
                        end else begin
                            state_q <= StRead;
                            readm_q <= 1'b1;
                        end
                    end
                end
                StRead, StWrite: begin
                    if (wait_q == 4'd0) begin
                        // Writes never touch IR, MDR or the fetch count.
                        if (state_q == StRead) begin
                            if (is_inst_q) begin
                                ir_q         <= data;
                                inst_count_q <= inst_count_q + 1'b1;
                            end else begin
                                mdr_q <= data;
                            end
                        end
                        state_q  <= StIdle;
                        readm_q  <= 1'b0;
                        writem_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    readm_q  <= 1'b0;
                    writem_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.done       = done_q;
    assign bus.ir_out     = ir_q;
    assign bus.mdr_out    = mdr_q;
    assign bus.inst_count = inst_count_q;
    assign bus.readM      = readm_q;
    assign bus.writeM     = writem_q;
    assign bus.address    = addr_q;

    // Drive the shared data bus only while a write strobe is active.
    assign data = writem_q ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: reset, table-driven accesses on a
// latency-2 instance, hand sequences for busy/reset/wrap corners, and a
// strobe-width sweep on latency-1 and latency-15 instances.
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic        req_is_inst;
    logic        sweep_en;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [15:0] rdata;

    wire  [15:0] data0;
    wire  [15:0] data1;
    wire  [15:0] data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_ctrl_if #(.WORD_SIZE(16)) if0 ();
    mem_port_ctrl_if #(.WORD_SIZE(16)) if1 ();
    mem_port_ctrl_if #(.WORD_SIZE(16)) if2 ();

    assign if0.req_valid   = req_valid;
    assign if0.req_write   = req_write;
    assign if0.req_is_inst = req_is_inst;
    assign if0.req_addr    = req_addr;
    assign if0.req_wdata   = req_wdata;

    assign if1.req_valid   = req_valid & sweep_en;
    assign if1.req_write   = req_write;
    assign if1.req_is_inst = req_is_inst;
    assign if1.req_addr    = req_addr;
    assign if1.req_wdata   = req_wdata;

    assign if2.req_valid   = req_valid & sweep_en;
    assign if2.req_write   = req_write;
    assign if2.req_is_inst = req_is_inst;
    assign if2.req_addr    = req_addr;
    assign if2.req_wdata   = req_wdata;

    // Memory models: return rdata whenever the read strobe is up.
    assign data0 = if0.readM ? rdata : 16'hzzzz;
    assign data1 = if1.readM ? rdata : 16'hzzzz;
    assign data2 = if2.readM ? rdata : 16'hzzzz;

    mem_port_ctrl #(.WORD_SIZE(16), .MEM_LATENCY(2)) u0 (
        .Clk     (clk),
        .Reset_N (rst_n),
        .bus     (if0),
        .data    (data0)
    );

    mem_port_ctrl #(.WORD_SIZE(16), .MEM_LATENCY(1)) u1 (
        .Clk     (clk),
        .Reset_N (rst_n),
        .bus     (if1),
        .data    (data1)
    );

    mem_port_ctrl #(.WORD_SIZE(16), .MEM_LATENCY(15)) u2 (
        .Clk     (clk),
        .Reset_N (rst_n),
        .bus     (if2),
        .data    (data2)
    );

    typedef struct packed {
        logic        write;
        logic        is_inst;
        logic        keep;      // hold req_valid through the access
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic [15:0] exp_ir;
        logic [15:0] exp_mdr;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on u0 (latency 2); checks acceptance, strobe, data and results.
    task automatic run_access(input vec_t v, input string tag);
        int   guard = 0;
        int   width = 0;
        int   dones = 0;
        logic addr_ok = 1'b1;
        logic data_ok = 1'b1;
        logic kind_ok = 1'b1;
        req_write   = v.write;
        req_is_inst = v.is_inst;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        rdata       = v.rdata;
        req_valid   = 1'b1;
        do begin
            tick();
            guard++;
        end while (!(if0.readM || if0.writeM) && guard < 10);
        check({tag, " accept_latency"}, 16'(guard), 16'd1);
        if (!v.keep) req_valid = 1'b0;
        while ((if0.readM || if0.writeM) && width < 20) begin
            width++;
            if (if0.address !== v.addr) addr_ok = 1'b0;
            if (if0.readM !== !v.write || if0.writeM !== v.write) kind_ok = 1'b0;
            if (v.write && data0 !== v.wdata) data_ok = 1'b0;
            if (if0.done) dones++;
            tick();
        end
        check({tag, " strobe_width"}, 16'(width), 16'd2);
        check({tag, " address"}, {15'd0, addr_ok}, 16'd1);
        check({tag, " strobe_kind"}, {15'd0, kind_ok}, 16'd1);
        if (v.write) check({tag, " write_data"}, {15'd0, data_ok}, 16'd1);
        check({tag, " done_early"}, 16'(dones), 16'd0);
        check({tag, " done"}, {15'd0, if0.done}, 16'd1);
        check({tag, " ready"}, {15'd0, if0.req_ready}, 16'd1);
        check({tag, " ir"}, if0.ir_out, v.exp_ir);
        check({tag, " mdr"}, if0.mdr_out, v.exp_mdr);
        check({tag, " inst_count"}, if0.inst_count, v.exp_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   w0, w1, w2, d1, d2;
        logic done_seen;

        //         wr    inst  keep  addr      wdata     rdata     ir        mdr       cnt
        vecs[0] = {1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hF01C, 16'hF01C, 16'h0000, 16'd1};
        vecs[1] = {1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h1234, 16'hF01C, 16'h1234, 16'd1};
        vecs[2] = {1'b1, 1'b0, 1'b0, 16'h0042, 16'hBEEF, 16'h5555, 16'hF01C, 16'h1234, 16'd1};
        vecs[3] = {1'b1, 1'b1, 1'b0, 16'h0044, 16'h0BAD, 16'h6666, 16'hF01C, 16'h1234, 16'd1};
        vecs[4] = {1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 16'hA5A5, 16'hA5A5, 16'h1234, 16'd2};
        vecs[5] = {1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0F0F, 16'hA5A5, 16'h0F0F, 16'd2};

        // Reset held for two edges with a request pending: reset wins.
        rst_n       = 1'b0;
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_is_inst = 1'b1;
        req_addr    = 16'h0123;
        req_wdata   = 16'h0000;
        rdata       = 16'h0000;
        sweep_en    = 1'b0;
        tick();
        tick();
        check("reset readM", {15'd0, if0.readM}, 16'd0);
        check("reset writeM", {15'd0, if0.writeM}, 16'd0);
        check("reset address", if0.address, 16'h0000);
        check("reset ir", if0.ir_out, 16'h0000);
        check("reset mdr", if0.mdr_out, 16'h0000);
        check("reset inst_count", if0.inst_count, 16'h0000);
        check("reset done", {15'd0, if0.done}, 16'd0);
        check("reset ready", {15'd0, if0.req_ready}, 16'd1);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_access(vecs[i], $sformatf("vec%0d", i));
        end
        tick();
        check("done single pulse", {15'd0, if0.done}, 16'd0);

        // Busy-request ignore: request inputs change during a read.
        req_write   = 1'b0;
        req_is_inst = 1'b0;
        req_addr    = 16'h0200;
        rdata       = 16'h7777;
        req_valid   = 1'b1;
        tick();
        check("busy readM start", {15'd0, if0.readM}, 16'd1);
        req_addr    = 16'h0300;
        req_write   = 1'b1;
        req_is_inst = 1'b1;
        check("busy address0", if0.address, 16'h0200);
        tick();
        check("busy address1", if0.address, 16'h0200);
        check("busy readM", {15'd0, if0.readM}, 16'd1);
        check("busy writeM", {15'd0, if0.writeM}, 16'd0);
        req_valid = 1'b0;
        tick();
        check("busy done", {15'd0, if0.done}, 16'd1);
        check("busy mdr", if0.mdr_out, 16'h7777);
        check("busy ir", if0.ir_out, 16'hA5A5);
        check("busy inst_count", if0.inst_count, 16'd2);
        check("busy no write", {15'd0, if0.writeM}, 16'd0);

        // Reset on the first read cycle of a fetch aborts it.
        req_write   = 1'b0;
        req_is_inst = 1'b1;
        req_addr    = 16'h0400;
        rdata       = 16'h9999;
        req_valid   = 1'b1;
        tick();
        check("abort readM start", {15'd0, if0.readM}, 16'd1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        tick();
        check("abort readM", {15'd0, if0.readM}, 16'd0);
        check("abort done", {15'd0, if0.done}, 16'd0);
        check("abort ir", if0.ir_out, 16'h0000);
        check("abort inst_count", if0.inst_count, 16'h0000);
        rst_n     = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (if0.done) done_seen = 1'b1;
        end
        check("abort done never", {15'd0, done_seen}, 16'd0);
        check("abort ir stays", if0.ir_out, 16'h0000);
        check("abort ready", {15'd0, if0.req_ready}, 16'd1);

        // Fetch-count wrap from a preset of 16'hFFFF.
        force u0.inst_count_q = 16'hFFFF;
        tick();
        release u0.inst_count_q;
        tick();
        check("wrap preset", if0.inst_count, 16'hFFFF);
        run_access({1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1357,
                    16'h1357, 16'h0000, 16'h0000}, "wrap");
        tick();

        // Latency sweep: one fetch accepted by all three instances together.
        sweep_en    = 1'b1;
        req_write   = 1'b0;
        req_is_inst = 1'b1;
        req_addr    = 16'h0055;
        rdata       = 16'hC0DE;
        req_valid   = 1'b1;
        tick();
        req_valid = 1'b0;
        w0 = 0; w1 = 0; w2 = 0; d1 = 0; d2 = 0;
        for (int i = 0; i < 20; i++) begin
            if (if0.readM) w0++;
            if (if1.readM) w1++;
            if (if2.readM) w2++;
            if (if1.done) d1++;
            if (if2.done) d2++;
            tick();
        end
        check("sweep L2 width", 16'(w0), 16'd2);
        check("sweep L1 width", 16'(w1), 16'd1);
        check("sweep L15 width", 16'(w2), 16'd15);
        check("sweep L1 done", 16'(d1), 16'd1);
        check("sweep L15 done", 16'(d2), 16'd1);
        check("sweep L1 ir", if1.ir_out, 16'hC0DE);
        check("sweep L15 ir", if2.ir_out, 16'hC0DE);
        check("sweep L1 inst_count", if1.inst_count, 16'd1);
        check("sweep L15 inst_count", if2.inst_count, 16'd1);
        check("sweep L15 address", if2.address, 16'h0055);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
